vga_timing_gen: RTL

- Generates 640x480@60 VGA raster timing from the 50 MHz system clock.
- Drives the pixel coordinate and display-enable inputs of the framebuffer stage.
- Drives the monitor's HSYNC/VSYNC through a delay line, so sync stays aligned with the framebuffer's RGB output after SRAM read latency.
- Sits directly upstream of the framebuffer in the display path.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/sync_delay_line.sv | 45 ++++
 rtl/vga_timing_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SYNC_POL   = 0;
    localparam int DEF_SYNC_DELAY = 1;

    localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    localparam int CNT_W          = 10;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enabled shift register of configurable width/depth; every stage resets to RESET_VAL.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = ^{clk, rst_n, srst, ce};
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift one stage per enabled clock; reset refills with the idle pattern
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VAL;
                    end
                end else if (srst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VAL;
                    end
                end else if (ce) begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, registered coordinates and
// sync/blanking delayed to line up with the framebuffer's read latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_POL   = DEF_SYNC_POL,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_ce,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       enable,
    output logic       de_out,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // 11-bit compare constants so a sum of exactly 1024 still compares correctly
    localparam logic [10:0] H_ACT_C    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_C    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START_C = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_C   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    localparam logic SYNC_ACT  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: timing sums do not fit the 10-bit counters");
        end
        if (V_ACTIVE > 512) begin : g_bad_vact
            $error("vga_timing_gen: V_ACTIVE exceeds the 9-bit y output");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be within 0..7");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_r;
    logic             pix_ce_r;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [9:0]       x_r;
    logic [8:0]       y_r;
    logic             enable_r;
    logic             hs_lvl_r;
    logic             vs_lvl_r;
    logic             wrap_pending_r;
    logic             frame_start_r;

    logic             div_last_s;
    logic             h_last_s;
    logic             v_last_s;
    logic             wrap_s;
    logic             fs_fire_s;
    logic             in_active_s;
    logic             hs_act_s;
    logic             vs_act_s;
    logic [2:0]       delay_in_s;
    logic [2:0]       delay_out_s;

    // Decode terminal counts and the raster regions of the current position
    always_comb begin
        div_last_s  = (div_cnt_r == DIV_LAST);
        h_last_s    = (h_cnt_r == H_LAST_C);
        v_last_s    = (v_cnt_r == V_LAST_C);
        wrap_s      = pix_ce_r && h_last_s && v_last_s;
        fs_fire_s   = div_last_s && (wrap_s || wrap_pending_r);
        in_active_s = ({1'b0, h_cnt_r} < H_ACT_C) && ({1'b0, v_cnt_r} < V_ACT_C);
        hs_act_s    = ({1'b0, h_cnt_r} >= HS_START_C) && ({1'b0, h_cnt_r} < HS_END_C);
        vs_act_s    = ({1'b0, v_cnt_r} >= VS_START_C) && ({1'b0, v_cnt_r} < VS_END_C);
        delay_in_s  = {hs_lvl_r, vs_lvl_r, enable_r};
    end

    // Pixel-rate divider; pix_ce is registered off the divider terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            pix_ce_r  <= 1'b0;
        end else begin
            pix_ce_r <= div_last_s;
            if (div_last_s) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
        end
    end

    // Raster position: h wraps each line and carries into v
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= 10'd0;
        end else if (pix_ce_r) begin
            if (h_last_s) begin
                h_cnt_r <= 10'd0;
                if (v_last_s) begin
                    v_cnt_r <= 10'd0;
                end else begin
                    v_cnt_r <= v_cnt_r + 10'd1;
                end
            end else begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end
        end
    end

    // Per-tick coordinate, enable and undelayed sync levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r      <= 10'd0;
            y_r      <= 9'd0;
            enable_r <= 1'b0;
            hs_lvl_r <= SYNC_IDLE;
            vs_lvl_r <= SYNC_IDLE;
        end else if (pix_ce_r) begin
            enable_r <= in_active_s;
            x_r      <= in_active_s ? h_cnt_r : 10'd0;
            y_r      <= in_active_s ? v_cnt_r[8:0] : 9'd0;
            hs_lvl_r <= hs_act_s ? SYNC_ACT : SYNC_IDLE;
            vs_lvl_r <= vs_act_s ? SYNC_ACT : SYNC_IDLE;
        end
    end

    // frame_start only follows a real frame wrap, so the post-reset (0,0) tick is skipped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_r  <= 1'b0;
            wrap_pending_r <= 1'b0;
        end else begin
            frame_start_r <= fs_fire_s;
            if (fs_fire_s) begin
                wrap_pending_r <= 1'b0;
            end else if (wrap_s) begin
                wrap_pending_r <= 1'b1;
            end
        end
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (1'b0),
        .ce    (pix_ce_r),
        .din   (delay_in_s),
        .dout  (delay_out_s)
    );

    assign pix_ce      = pix_ce_r;
    assign x           = x_r;
    assign y           = y_r;
    assign enable      = enable_r;
    assign frame_start = frame_start_r;
    assign hsync       = delay_out_s[2];
    assign vsync       = delay_out_s[1];
    assign de_out      = delay_out_s[0];

endmodule
